// File: rtl/key_debounce_if.sv
// key_debounce_if: key bundle between the raw buttons and the debouncer
//   key_in      raw active-low buttons (0 = pressed)
//   key_state   debounced level, 1 = pressed
//   key_press   one-cycle pulse on an accepted press
//   key_release one-cycle pulse on an accepted release
//   key_long    one-cycle pulse once per press after the long-hold time
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    modport master (output key_in, input key_state, key_press, key_release, key_long);
    modport slave  (input key_in, output key_state, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: multi-key synchroniser, debouncer and press/release/long-press event generator
//   sys_clk_50M  system clock
//   rst_n        asynchronous active-low reset
//   kif.key_in   raw active-low buttons, asynchronous to the clock
//   kif.key_state / key_press / key_release / key_long  registered per-key results
module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic          sys_clk_50M,
    input  logic          rst_n,
    key_debounce_if.slave kif
);
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
    localparam logic [CNT_W-1:0] DB_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    state_t              st      [NUM_KEYS];
    state_t              st_nx   [NUM_KEYS];
    logic [CNT_W-1:0]    dcnt    [NUM_KEYS];
    logic [CNT_W-1:0]    dcnt_nx [NUM_KEYS];
    logic [CNT_W-1:0]    hcnt    [NUM_KEYS];
    logic [CNT_W-1:0]    hcnt_nx [NUM_KEYS];
    logic [NUM_KEYS-1:0] s1, s2;
    logic [NUM_KEYS-1:0] state_q, state_nx;
    logic [NUM_KEYS-1:0] press_q, press_nx;
    logic [NUM_KEYS-1:0] rel_q, rel_nx;
    logic [NUM_KEYS-1:0] long_q, long_nx;
    always_ff @(posedge sys_clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '1;
            s2      <= '1;
            state_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                st[i]   <= IDLE;
                dcnt[i] <= '0;
                hcnt[i] <= '0;
            end
        end else begin
            s1      <= kif.key_in;
            s2      <= s1;
            state_q <= state_nx;
            press_q <= press_nx;
            rel_q   <= rel_nx;
            long_q  <= long_nx;
            for (int i = 0; i < NUM_KEYS; i++) begin
                st[i]   <= st_nx[i];
                dcnt[i] <= dcnt_nx[i];
                hcnt[i] <= hcnt_nx[i];
            end
        end
    end
    always_comb begin
        state_nx = state_q;
        press_nx = '0;
        rel_nx   = '0;
        long_nx  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            st_nx[i]   = st[i];
            dcnt_nx[i] = dcnt[i];
            hcnt_nx[i] = hcnt[i];
            case (st[i])
                IDLE: begin
                    if (!s2[i]) begin
                        st_nx[i]   = PRESS_DB;
                        dcnt_nx[i] = '0;
                    end
                end
                PRESS_DB: begin
                    if (s2[i]) begin
                        st_nx[i] = IDLE;
                    end else if (dcnt[i] == DB_MAX) begin
                        st_nx[i]    = HELD;
                        press_nx[i] = 1'b1;
                        state_nx[i] = 1'b1;
                        hcnt_nx[i]  = '0;
                    end else begin
                        dcnt_nx[i] = dcnt[i] + ONE;
                    end
                end
                HELD: begin
                    if (s2[i]) begin
                        st_nx[i]   = RELEASE_DB;
                        dcnt_nx[i] = '0;
                    end else begin
                        // hcnt stops at HOLD_MAX, so the long pulse can fire only once per press
                        hcnt_nx[i] = (hcnt[i] < HOLD_MAX) ? hcnt[i] + ONE : hcnt[i];
                        long_nx[i] = (hcnt[i] == HOLD_FIRE);
                    end
                end
                RELEASE_DB: begin
                    // a bounce back to HELD keeps hcnt, so release glitches do not restart the long timer
                    if (!s2[i]) begin
                        st_nx[i] = HELD;
                    end else if (dcnt[i] == DB_MAX) begin
                        st_nx[i]    = IDLE;
                        rel_nx[i]   = 1'b1;
                        state_nx[i] = 1'b0;
                    end else begin
                        dcnt_nx[i] = dcnt[i] + ONE;
                    end
                end
                default: st_nx[i] = IDLE;
            endcase
        end
    end
    assign kif.key_state   = state_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = rel_q;
    assign kif.key_long    = long_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized checks of key_debounce against a run-length reference model
module tb_key_debounce;
    localparam int NK = 4;
    localparam int DB = 10;
    localparam int LG = 50;

    logic sys_clk_50M = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    key_debounce_if #(.NUM_KEYS(NK)) kif ();

    key_debounce #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .CNT_W(26)
    ) dut (
        .sys_clk_50M(sys_clk_50M),
        .rst_n(rst_n),
        .kif(kif)
    );

    always #10 sys_clk_50M = ~sys_clk_50M;

    // Reference model: a level change is accepted after DB+1 consecutive differing samples of the
    // twice-delayed input; hold time counts pressed samples not interrupted by a release glitch.
    logic [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_long;
    logic m_p;
    int m_run [NK];
    int m_hold [NK];

    always @(posedge sys_clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_hold[i] = 0; end
        end else begin
            for (int i = 0; i < NK; i++) begin
                m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
                m_p = ~m_s2[i];
                if (m_p != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_lvl[i] = m_p;
                        m_run[i] = 0;
                        if (m_p) begin m_press[i] = 1'b1; m_hold[i] = 0; end
                        else m_rel[i] = 1'b1;
                    end
                end else begin
                    if (m_lvl[i] && m_run[i] == 0) begin
                        if (m_hold[i] == LG - 2) m_long[i] = 1'b1;
                        if (m_hold[i] < LG - 1) m_hold[i]++;
                    end
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = kif.key_in;
        end
    end

    task automatic test_reset();
        logic [4*NK-1:0] got;
        rst_n = 1'b0;
        kif.key_in = '1;
        repeat (3) @(negedge sys_clk_50M);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk_50M);
            got = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
            total++;
            if (got !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h want=0", c, got);
            end
        end
    endtask

    task automatic test_press();
        int rel_cnt = 0;
        logic [4*NK-1:0] got, want;
        @(negedge sys_clk_50M);
        kif.key_in = 4'b1110;
        for (int i = 0; i < 14; i++) begin
            @(negedge sys_clk_50M);
            total++;
            if (kif.key_press !== ((i == 12) ? 4'b0001 : 4'b0000) || kif.key_state[0] !== (i >= 12)) begin
                bad++;
                $display("FAIL press_timing edge=%0d press=%b state=%b", i, kif.key_press, kif.key_state);
            end
        end
        kif.key_in = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk_50M);
            if (kif.key_release[0]) rel_cnt++;
            got = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
            want = {m_lvl, m_press, m_rel, m_long};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL press_model cyc=%0d got=%h want=%h", i, got, want);
            end
        end
        total++;
        if (rel_cnt !== 1 || kif.key_state !== 4'b0000) begin
            bad++;
            $display("FAIL press_release count=%0d want=1 state=%b", rel_cnt, kif.key_state);
        end
    endtask

    task automatic test_bounce();
        int ev = 0;
        logic [4*NK-1:0] got, want;
        for (int c = 0; c < 60; c++) begin
            kif.key_in[1] = (c < 40) ? (((c / 4) % 2) == 1) : 1'b1;
            @(negedge sys_clk_50M);
            if (kif.key_press[1] || kif.key_release[1] || kif.key_state[1]) ev++;
            got = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
            want = {m_lvl, m_press, m_rel, m_long};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL bounce_model cyc=%0d got=%h want=%h", c, got, want);
            end
        end
        total++;
        if (ev !== 0) begin
            bad++;
            $display("FAIL bounce_events got=%0d want=0", ev);
        end
    endtask

    task automatic test_long();
        int pc = 0, lc = 0, rc = 0;
        logic [4*NK-1:0] got, want;
        kif.key_in[2] = 1'b0;
        for (int i = 0; i < 130; i++) begin
            @(negedge sys_clk_50M);
            if (i == 99) kif.key_in[2] = 1'b1;
            pc += int'(kif.key_press[2]);
            lc += int'(kif.key_long[2]);
            rc += int'(kif.key_release[2]);
            total++;
            if (kif.key_long[2] !== (i == 61) || kif.key_release[2] !== (i == 112)) begin
                bad++;
                $display("FAIL long_timing edge=%0d long=%b rel=%b", i, kif.key_long[2], kif.key_release[2]);
            end
            got = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
            want = {m_lvl, m_press, m_rel, m_long};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL long_model cyc=%0d got=%h want=%h", i, got, want);
            end
        end
        total++;
        if (pc !== 1 || lc !== 1 || rc !== 1 || kif.key_state[2] !== 1'b0) begin
            bad++;
            $display("FAIL long_counts press=%0d long=%0d rel=%0d want 1/1/1", pc, lc, rc);
        end
    endtask

    task automatic test_all_keys();
        int pf = 0, rf = 0, partial = 0, lc = 0;
        logic [4*NK-1:0] got, want;
        kif.key_in = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk_50M);
            if (i == 29) kif.key_in = '1;
            if (kif.key_press == 4'hF) pf++;
            else if (kif.key_press != 4'h0) partial++;
            if (kif.key_release == 4'hF) rf++;
            else if (kif.key_release != 4'h0) partial++;
            if (kif.key_long != 4'h0) lc++;
            got = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
            want = {m_lvl, m_press, m_rel, m_long};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL all_model cyc=%0d got=%h want=%h", i, got, want);
            end
        end
        total++;
        if (pf !== 1 || rf !== 1 || partial !== 0 || lc !== 0) begin
            bad++;
            $display("FAIL all_counts press=%0d rel=%0d partial=%0d long=%0d want 1/1/0/0", pf, rf, partial, lc);
        end
    endtask

    task automatic test_reset_mid();
        int rc = 0;
        logic [4*NK-1:0] got;
        kif.key_in = 4'b1110;
        repeat (20) @(negedge sys_clk_50M);
        total++;
        if (kif.key_state !== 4'b0001) begin
            bad++;
            $display("FAIL mid_held got=%b want=0001", kif.key_state);
        end
        rst_n = 1'b0;
        #1;
        got = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL mid_async_clear got=%h want=0", got);
        end
        repeat (2) @(negedge sys_clk_50M);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge sys_clk_50M);
            rc += int'(kif.key_release[0]);
            total++;
            if (kif.key_press !== ((i == 12) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL mid_repress edge=%0d press=%b", i, kif.key_press);
            end
        end
        total++;
        if (rc !== 0) begin
            bad++;
            $display("FAIL mid_no_release got=%0d want=0", rc);
        end
        kif.key_in = '1;
        repeat (20) @(negedge sys_clk_50M);
    endtask

    task automatic test_random();
        int left [NK];
        logic [4*NK-1:0] got, want;
        for (int k = 0; k < NK; k++) left[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (left[k] == 0) begin
                    kif.key_in[k] = ~kif.key_in[k];
                    left[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(DB, LG + 20) : $urandom_range(1, DB + 2);
                end
                left[k]--;
            end
            @(negedge sys_clk_50M);
            got = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
            want = {m_lvl, m_press, m_rel, m_long};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", c, got, want);
            end
        end
    endtask

    initial begin
        kif.key_in = '1;
        test_reset();
        test_press();
        test_bounce();
        test_long();
        test_all_keys();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
